// File: rtl/grn_step_ctrl.sv
// grn_step_ctrl: sequencer for a gene-regulatory-network attractor search.
// It loads the node array, then steps a tortoise chain (s0) and a hare chain
// (s1) together and watches for the two to meet. The hare advances twice as
// fast, so on even steps s0 = f^(k/2) and s1 = f^k.
// Optional feature macro: GRN_PERIOD_EN. When defined, the block also
// measures the cycle length by stepping the hare alone until it returns to
// the matched state.
module grn_step_ctrl #(
  parameter int N_NODES = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_NODES-1:0] init_vec,
  input  logic [CNT_W-1:0]   max_steps,
  output logic               reset_nos,
  output logic               start_s0,
  output logic               start_s1,
  output logic [N_NODES-1:0] init_state,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   out_steps,
  output logic [CNT_W-1:0]   out_period,
  output logic [N_NODES-1:0] out_state,
  output logic               out_timeout
);

`ifdef GRN_PERIOD_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STEP, S_WAIT, S_PSTEP, S_PWAIT, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STEP, S_WAIT, S_DONE
  } state_t;
`endif

  state_t state, state_next;

  logic [CNT_W-1:0] max_r;
  logic [CNT_W-1:0] step_cnt;
  logic             capture;
  logic             step_inc;
  logic             latch_match;
  logic             latch_steps;
  logic             latch_to;
  logic             even_match;

`ifdef GRN_PERIOD_EN
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] period_r;
  logic             period_inc;
  logic             latch_period;
`endif

  // State register; reset always returns to IDLE so strobes drop immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode plus one-cycle strobes and datapath enables.
  always_comb begin
    state_next  = state;
    reset_nos   = 1'b0;
    start_s0    = 1'b0;
    start_s1    = 1'b0;
    capture     = 1'b0;
    step_inc    = 1'b0;
    latch_match = 1'b0;
    latch_steps = 1'b0;
    latch_to    = 1'b0;
`ifdef GRN_PERIOD_EN
    period_inc   = 1'b0;
    latch_period = 1'b0;
`endif
    // Odd steps leave the tortoise between states, so they are never compared.
    even_match = !step_cnt[0] && (s0_vec == s1_vec);
    busy       = (state != S_IDLE);
    out_valid  = (state == S_DONE);
    case (state)
      S_IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        reset_nos = 1'b1;
        if (max_r == '0) begin
          latch_to   = 1'b1;
          state_next = S_DONE;
        end else begin
          state_next = S_STEP;
        end
      end
      S_STEP: begin
        start_s0   = 1'b1;
        start_s1   = 1'b1;
        step_inc   = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (even_match) begin
          latch_match = 1'b1;
          latch_steps = 1'b1;
`ifdef GRN_PERIOD_EN
          state_next  = S_PSTEP;
`else
          state_next  = S_DONE;
`endif
        end else if (step_cnt == max_r) begin
          latch_steps = 1'b1;
          latch_to    = 1'b1;
          state_next  = S_DONE;
        end else begin
          state_next = S_STEP;
        end
      end
`ifdef GRN_PERIOD_EN
      S_PSTEP: begin
        start_s1   = 1'b1;
        period_inc = 1'b1;
        state_next = S_PWAIT;
      end
      S_PWAIT: begin
        if (s1_vec == out_state) begin
          latch_period = 1'b1;
          state_next   = S_DONE;
        end else if (period_cnt == max_r) begin
          latch_to   = 1'b1;
          state_next = S_DONE;
        end else begin
          state_next = S_PSTEP;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Captured run parameters, counters and result fields; a new run starts clean.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_state  <= '0;
      max_r       <= '0;
      step_cnt    <= '0;
      out_steps   <= '0;
      out_state   <= '0;
      out_timeout <= 1'b0;
    end else begin
      if (capture) begin
        init_state  <= init_vec;
        max_r       <= max_steps;
        step_cnt    <= '0;
        out_steps   <= '0;
        out_state   <= '0;
        out_timeout <= 1'b0;
      end
      if (step_inc)    step_cnt    <= step_cnt + CNT_W'(1);
      if (latch_steps) out_steps   <= step_cnt;
      if (latch_match) out_state   <= s1_vec;
      if (latch_to)    out_timeout <= 1'b1;
    end
  end

`ifdef GRN_PERIOD_EN
  // Period counter runs only while the hare walks the cycle alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_cnt <= '0;
      period_r   <= '0;
    end else begin
      if (capture) begin
        period_cnt <= '0;
        period_r   <= '0;
      end
      if (period_inc)   period_cnt <= period_cnt + CNT_W'(1);
      if (latch_period) period_r   <= period_cnt;
    end
  end

  assign out_period = period_r;
`else
  assign out_period = '0;
`endif

endmodule

// File: tb/tb_grn_step_ctrl.sv
// tb_grn_step_ctrl: directed table-driven bench for grn_step_ctrl, with a
// behavioural node array (tortoise advances on every second s0 strobe).
module tb_grn_step_ctrl;

`ifdef GRN_PERIOD_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  init_vec;
  logic [15:0] max_steps;
  logic        reset_nos, start_s0, start_s1;
  logic [7:0]  init_state;
  logic [7:0]  s0_vec, s1_vec;
  logic        busy, out_valid, out_ready;
  logic [15:0] out_steps, out_period;
  logic [7:0]  out_state;
  logic        out_timeout;

  int   f_mode;
  logic ph;
  int   n_total, n_pass;
  int   lat, n_s0, n_s1, n_rn, consec, seen;
  logic [7:0] cap_state;

  typedef struct {
    int         mode;
    logic [7:0] init;
    int         maxs;
    int         exp_steps;
    logic [7:0] exp_state;
    int         chk_state;
    int         exp_to;
    int         exp_period;
    int         exp_lat;
    int         exp_s0;
    int         exp_s1;
  } vec_t;

  vec_t vecs[5];

  grn_step_ctrl #(.N_NODES(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init_vec(init_vec),
    .max_steps(max_steps), .reset_nos(reset_nos), .start_s0(start_s0),
    .start_s1(start_s1), .init_state(init_state), .s0_vec(s0_vec),
    .s1_vec(s1_vec), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_steps(out_steps), .out_period(out_period),
    .out_state(out_state), .out_timeout(out_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] nf(input int mode, input logic [7:0] x);
    case (mode)
      1:       return ~x;
      2:       return x + 8'd1;
      default: return x;
    endcase
  endfunction

  // Node array model: hare steps on every s1 strobe, tortoise on every second s0 strobe.
  always @(posedge clk) begin
    if (reset_nos) begin
      s0_vec <= init_state;
      s1_vec <= init_state;
      ph     <= 1'b0;
    end else begin
      if (start_s1) s1_vec <= nf(f_mode, s1_vec);
      if (start_s0) begin
        ph <= ~ph;
        if (ph) s0_vec <= nf(f_mode, s0_vec);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Starts a run and waits (bounded) for out_valid, counting strobes on the way.
  task automatic applyStimulus(input int mode, input logic [7:0] iv, input int ms);
    int   cyc;
    logic prev;
    f_mode    = mode;
    init_vec  = iv;
    max_steps = 16'(ms);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    cap_state = init_state;
    cyc = 1; n_s0 = 0; n_s1 = 0; n_rn = 0; consec = 0; seen = 0; prev = 1'b0;
    while (cyc < 400 && seen == 0) begin
      if (out_valid) begin
        seen = 1;
        lat  = cyc;
      end else begin
        n_s0 += int'(start_s0);
        n_s1 += int'(start_s1);
        n_rn += int'(reset_nos);
        if ((start_s0 || start_s1) && prev) consec++;
        prev = start_s0 || start_s1;
        @(posedge clk); #1;
        cyc++;
      end
    end
    checkOutput("valid_seen", seen, 1);
  endtask

  task automatic ackResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("idle_after_ack", int'(busy), 0);
  endtask

  initial begin
    n_total = 0; n_pass = 0;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    init_vec = '0; max_steps = '0; f_mode = 0; lat = 0;

    //        mode init  max steps state chk to per          lat            s0  s1
    vecs[0] = '{0, 8'h5A, 20, 2,  8'h5A, 1, 0, PEN ? 1 : 0, PEN ? 8 : 6,   2,  PEN ? 3 : 2};
    vecs[1] = '{1, 8'h0F, 20, 4,  8'h0F, 1, 0, PEN ? 2 : 0, PEN ? 14 : 10, 4,  PEN ? 6 : 4};
    vecs[2] = '{2, 8'h00, 10, 10, 8'h00, 0, 1, 0,           22,            10, 10};
    vecs[3] = '{0, 8'h33, 0,  0,  8'h00, 0, 1, 0,           2,             0,  0};
    vecs[4] = '{2, 8'hFE, 3,  3,  8'h00, 0, 1, 0,           8,             3,  3};

    @(posedge clk); @(posedge clk); #1;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_strobes", int'({reset_nos, start_s0, start_s1}), 0);
    checkOutput("rst_init_state", int'(init_state), 0);
    checkOutput("rst_out_steps", int'(out_steps), 0);
    checkOutput("rst_out_timeout", int'(out_timeout), 0);
    checkOutput("rst_out_period", int'(out_period), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i].mode, vecs[i].init, vecs[i].maxs);
      checkOutput("init_capture", int'(cap_state), int'(vecs[i].init));
      checkOutput("latency", lat, vecs[i].exp_lat);
      checkOutput("out_steps", int'(out_steps), vecs[i].exp_steps);
      if (vecs[i].chk_state != 0)
        checkOutput("out_state", int'(out_state), int'(vecs[i].exp_state));
      checkOutput("out_timeout", int'(out_timeout), vecs[i].exp_to);
      checkOutput("out_period", int'(out_period), vecs[i].exp_period);
      checkOutput("reset_nos_pulses", n_rn, 1);
      checkOutput("s0_pulses", n_s0, vecs[i].exp_s0);
      checkOutput("s1_pulses", n_s1, vecs[i].exp_s1);
      checkOutput("consecutive_strobes", consec, 0);
      ackResult();
    end

    // Result held through a stalled handshake; a start pulse during DONE is dropped.
    $display("[TB] hold and ignored start");
    applyStimulus(0, 8'h5A, 20);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", int'(out_valid), 1);
      checkOutput("hold_steps", int'(out_steps), 2);
      checkOutput("hold_state", int'(out_state), 32'h5A);
      start    = (i == 1);
      init_vec = 8'hFF;
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkOutput("ignored_start_init", int'(init_state), 32'h5A);
    ackResult();
    @(posedge clk); #1;
    checkOutput("start_not_queued", int'(busy), 0);

    // Reset asserted for one cycle during step 3 aborts the run cleanly.
    $display("[TB] mid-run reset");
    f_mode = 2; init_vec = 8'h00; max_steps = 16'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int cnt;
      int guard;
      cnt = 0; guard = 0;
      while (cnt < 3 && guard < 100) begin
        if (start_s0) cnt++;
        if (cnt < 3) begin
          @(posedge clk); #1;
        end
        guard++;
      end
      checkOutput("reached_step3", cnt, 3);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_valid", int'(out_valid), 0);
    checkOutput("abort_strobes", int'({reset_nos, start_s0, start_s1}), 0);
    begin
      int any;
      any = 0;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        any += int'(out_valid) + int'(busy) + int'(start_s0) + int'(start_s1);
      end
      checkOutput("abort_quiet", any, 0);
    end
    applyStimulus(0, 8'h5A, 20);
    checkOutput("rerun_latency", lat, PEN ? 8 : 6);
    checkOutput("rerun_steps", int'(out_steps), 2);
    checkOutput("rerun_state", int'(out_state), 32'h5A);
    checkOutput("rerun_timeout", int'(out_timeout), 0);
    checkOutput("rerun_period", int'(out_period), PEN);
    ackResult();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/grn_step_ctrl.md
GRN_STEP_CTRL -- requirements
Module: grn_step_ctrl

Interface
REQ-001 SHALL have parameter N_NODES, default 8: number of network nodes; sets the width of the state vectors.
REQ-002 SHALL have parameter CNT_W, default 16: width of the step and period counters.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-006 SHALL have port init_vec, input, N_NODES bits: initial network state, captured when start is accepted.
REQ-007 SHALL have port max_steps, input, CNT_W bits: step bound, captured when start is accepted.
REQ-008 SHALL have port reset_nos, output, 1 bit: node load strobe.
REQ-009 SHALL have port start_s0, output, 1 bit: tortoise-chain step strobe.
REQ-010 SHALL have port start_s1, output, 1 bit: hare-chain step strobe.
REQ-011 SHALL have port init_state, output, N_NODES bits: per-node initial state (bit i drives node i).
REQ-012 SHALL have port s0_vec, input, N_NODES bits: concatenated node s0 outputs.
REQ-013 SHALL have port s1_vec, input, N_NODES bits: concatenated node s1 outputs.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port out_valid, output, 1 bit: result valid.
REQ-016 SHALL have port out_ready, input, 1 bit: result accepted.
REQ-017 SHALL have ports out_steps (CNT_W), out_period (CNT_W), out_state (N_NODES) and out_timeout (1), all outputs: the result fields.

Function
REQ-018 SHALL implement the FSM IDLE -> LOAD -> STEP <-> WAIT -> [PSTEP <-> PWAIT] -> DONE -> IDLE.
REQ-019 IDLE SHALL go to LOAD when start=1; on that edge it captures init_vec into init_state and max_steps, and clears step_cnt and period_cnt.
REQ-020 LOAD SHALL assert reset_nos for exactly one cycle; next state is STEP, or DONE with out_timeout=1 and out_steps=0 if max_steps=0.
REQ-021 STEP SHALL assert start_s0 and start_s1 together for one cycle and increment step_cnt; next state is WAIT.
REQ-022 WAIT SHALL compare node outputs only when step_cnt[0]=0 (even steps: s0=f^(k/2), s1=f^k); odd steps are never compared.
REQ-023 In WAIT, on an even step with s0_vec==s1_vec, the block SHALL latch out_state=s1_vec and out_steps=step_cnt, then go to PSTEP (REQ-031) or DONE.
REQ-024 In WAIT with no match, the block SHALL go to DONE with out_timeout=1 if step_cnt==max_steps, else back to STEP.
REQ-025 The step rate SHALL be one step per 2 cycles; strobes SHALL never be asserted in consecutive cycles.
REQ-026 DONE SHALL hold out_valid=1 with stable result fields until out_ready=1; the handshake completes on the edge where both are 1, then the FSM goes to IDLE.
REQ-027 A start asserted while busy=1 SHALL be ignored and not queued.
REQ-028 step_cnt SHALL NOT wrap, since it is bounded by max_steps.

Reset
REQ-029 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE, and all outputs, counters and captured registers SHALL clear to 0.
REQ-030 Reset mid-run SHALL abort the run with no out_valid; node strobes SHALL be 0 from the first cycle after the reset edge.

Configuration
REQ-031 With GRN_PERIOD_EN defined, after a match the block SHALL run PSTEP (start_s1 only, period_cnt+1) and PWAIT; PWAIT compares s1_vec==out_state.
REQ-032 With GRN_PERIOD_EN, an equal compare in PWAIT SHALL latch out_period=period_cnt and go to DONE; period_cnt==max_steps SHALL go to DONE with out_timeout=1.
REQ-033 Without GRN_PERIOD_EN, PSTEP and PWAIT SHALL be absent, out_period SHALL be tied to 0, and a match SHALL go directly to DONE.

Verification
REQ-034 Bench SHALL use node models with f(x)=x, init 0x5A, max_steps 20 -> out_valid in cycle 6 after start; out_steps=2, out_state=0x5A, out_timeout=0, out_period=1 (with EN).
REQ-035 Bench SHALL use f(x)=~x, init 0x0F -> step 2 has no match (0xF0 vs 0x0F); out_steps=4, out_state=0x0F, out_period=2 (with EN).
REQ-036 Bench SHALL use f(x)=x+1 mod 256, max_steps 10 -> out_timeout=1, out_steps=10, exactly 10 start_s1 pulses.
REQ-037 Bench SHALL hold out_ready=0 for 5 cycles in DONE and pulse start -> result held stable, start ignored, IDLE one cycle after out_ready=1.
REQ-038 Bench SHALL drive rst_n=0 for one cycle at step 3 -> busy=0, no out_valid, strobes 0; a new start then yields the correct result.
REQ-039 Bench SHALL set max_steps=0 -> one reset_nos pulse, no step strobes, out_timeout=1, out_steps=0.
